pwm_multi_ch: RTL and testbench
===============================

// Module: pwm_multi_ch
// PURPOSE
//  Multi-channel, parametrised PWM generator driven by ALU/register results.
//  One shared period counter feeds CH per-channel duty comparators.
//  Adds over the single-channel PWM: programmable period, edge- or center-aligned
//  mode, double-buffered glitch-free updates at period boundaries, per-channel inversion.
//  Sits between the ALU/config registers and the FPGA output pins.
// PARAMETERS
//  CH        4        number of PWM channels
//  W         8        counter/period/duty width in bits
//  INV_MASK  '0       CH-bit mask; bit i=1 inverts output pwm[i] (idle level = 1)
// PORTS
//  clk         in   1      single system clock, all logic on posedge
//  rst         in   1      synchronous, active-low reset (rst==0 at posedge clk resets)
//  en          in   1      1 = run counter; 0 = hold counter at 0, outputs idle
//  load        in   1      1-cycle strobe: capture mode/period/duty into shadow regs
//  mode        in   1      0 = edge-aligned, 1 = center-aligned
//  period      in   W      period value P
//  duty        in   CH*W   packed duty values; channel i = duty[i*W +: W]
//  pwm         out  CH     registered PWM outputs
//  period_tick out  1      1-cycle pulse, high on last cycle of each period
//  upd_pending out  1      shadow holds values not yet applied
// BEHAVIOUR
//  Reset: cnt=0, dir=up, active/shadow P=0, duty=0, mode=edge,
//   pwm=INV_MASK, period_tick=0, upd_pending=0.
//  Edge mode: cnt runs 0..P, then wraps to 0; period = P+1 cycles.
//   raw_i = (cnt < D_i); D_i=0 -> 0%; D_i>P -> 100%.
//  Center mode: cnt runs up 0..P-1, then down P-1..0; each endpoint is held
//   for 2 cycles; period = 2P cycles.
//   raw_i = (cnt < D_i); the high time is exactly 2*D_i cycles, centred on cnt==0.
//   D_i>=P -> 100%. P==0 -> cnt held at 0, raw_i=0, tick never fires.
//  Output register: pwm[i] <= raw_i ^ INV_MASK[i]; 1-cycle latency from cnt.
//  period_tick (registered with the same alignment as pwm) is asserted on:
//   - edge mode: cnt==P;
//   - center mode: down phase with cnt==0.
//  Double buffer: load=1 -> shadow <= {mode,period,duty}, upd_pending <= 1.
//   At the boundary (cycle after tick): active <= shadow and upd_pending <= 0;
//   cnt restarts at 0, dir=up.
//  Simultaneous load + boundary: the inputs on that cycle go straight to active;
//   upd_pending stays 0.
//  Multiple loads within one period: the last one wins.
//  en=0: cnt=0, dir=up, pwm=INV_MASK, tick=0; loads are still accepted.
//   On the first cycle with en=1, a pending shadow is applied before counting.
//  No mid-period change of P/D/mode ever reaches the comparators (glitch-free).
//  Mode switch takes effect only at the boundary; cnt and dir restart cleanly.
//  Reset mid-period: everything returns to reset values on the next posedge.
//  All compares are unsigned W-bit; cnt never exceeds max(P, P-1).
// STRUCTURE
//  Package pwm_pkg:
//   - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e
//   - typedef logic [W-1:0] pwm_val_t (via parameterised localparam)
//   - reset constants
//  Sub-module pwm_cmp_ch: one channel. Holds the shadow/active duty regs, the
//   compare and the output flop (inv bit as a parameter); instanced CH times by generate.
//  Top: shared counter/direction FSM {IDLE, UP, DOWN}, shadow period/mode, tick, pending.
// TESTING
//  1. CH=4, W=8, edge, P=9, D={0,3,10,255}, load, en=1
//     -> per 10-cycle period: highs = 0,3,10,10; tick every 10 cycles.
//  2. Center, P=8, D=3, load, en=1
//     -> period 16; pwm high 6 consecutive cycles spanning the cnt==0 wrap; tick every 16.
//  3. Mid-period load of D=7 (was 2) at cnt=4
//     -> current period keeps 2 highs; upd_pending=1 until the boundary; next period 7 highs.
//  4. load asserted on the same cycle as tick
//     -> new values active in the very next period; upd_pending never asserts.
//  5. INV_MASK=4'b0101; en=0, then rst=0 mid-period
//     -> pwm=4'b0101, tick=0, cnt back to 0 on the next posedge.
//  6. Edge P=0, D=1 -> pwm constantly 1, tick every cycle;
//     switch to center P=0 -> pwm=0, no tick.

Source files
------------

// File: rtl/pwm_multi_ch_pkg.sv
// Shared types and reset constants for the multi-channel PWM generator.
// No logic; latency and backpressure do not apply.
package pwm_pkg;
  localparam int PWM_W = 8;

  typedef logic [PWM_W-1:0] pwm_val_t;
  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} cnt_st_e;

  localparam pwm_mode_e RST_MODE = PWM_EDGE;
  localparam pwm_val_t  RST_VAL  = '0;
endpackage

// File: rtl/pwm_multi_ch_cmp.sv
// One PWM channel: shadow/active duty, unsigned compare against the shared counter.
// Output is registered, 1 cycle after cnt; no backpressure.
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int   W   = PWM_W,
  parameter logic INV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         apply_i,
  input  logic         run_i,
  input  logic         blank_i,
  input  logic [W-1:0] duty_i,
  input  logic [W-1:0] cnt_i,
  output logic         pwm_o
);
  logic [W-1:0] sh_q;
  logic [W-1:0] act_q;
  logic         pwm_q;
  logic         pwm_d;

  always_comb begin
    pwm_d = INV;
    if (run_i) begin
      pwm_d = ((cnt_i < act_q) & ~blank_i) ^ INV;
    end
  end

  // A load coinciding with apply bypasses the shadow so both stay in step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q  <= W'(RST_VAL);
      act_q <= W'(RST_VAL);
      pwm_q <= INV;
    end else begin
      if (load_i) begin
        sh_q <= duty_i;
      end
      if (apply_i) begin
        act_q <= load_i ? duty_i : sh_q;
      end
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared edge/center counter, double-buffered period/mode/duty.
// pwm and period_tick are registered 1 cycle after cnt; no backpressure.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int          CH       = 4,
  parameter int          W        = PWM_W,
  parameter logic [CH-1:0] INV_MASK = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic            mode,
  input  logic [W-1:0]    period,
  input  logic [CH*W-1:0] duty,
  output logic [CH-1:0]   pwm,
  output logic            period_tick,
  output logic            upd_pending
);
  cnt_st_e   st_q, st_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] per_sh_q, per_act_q;
  pwm_mode_e mode_sh_q, mode_act_q;
  logic      pend_q;
  logic      tick_q;
  logic      term;
  logic      apply;
  logic      run;
  logic      blank;

  assign run   = en && (st_q != ST_IDLE);
  assign blank = (mode_act_q == PWM_CENTER) && (per_act_q == '0);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    term  = 1'b0;
    apply = 1'b0;
    if (!en) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          apply = 1'b1;
          st_d  = ST_UP;
          cnt_d = '0;
        end
        ST_UP: begin
          if (mode_act_q == PWM_EDGE) begin
            if (cnt_q == per_act_q) term = 1'b1;
            else                    cnt_d = cnt_q + W'(1);
          end else if (per_act_q == '0) begin
            cnt_d = '0;
          end else if (cnt_q == per_act_q - W'(1)) begin
            st_d = ST_DOWN;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        ST_DOWN: begin
          if (cnt_q == '0) term = 1'b1;
          else             cnt_d = cnt_q - W'(1);
        end
        default: st_d = ST_IDLE;
      endcase
      // Period boundary: pick up the shadow and restart the sweep cleanly.
      if (term) begin
        apply = 1'b1;
        st_d  = ST_UP;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      per_sh_q   <= '0;
      per_act_q  <= '0;
      mode_sh_q  <= RST_MODE;
      mode_act_q <= RST_MODE;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tick_q <= term;
      if (load) begin
        per_sh_q  <= period;
        mode_sh_q <= pwm_mode_e'(mode);
      end
      if (apply) begin
        per_act_q  <= load ? period : per_sh_q;
        mode_act_q <= load ? pwm_mode_e'(mode) : mode_sh_q;
      end
      pend_q <= apply ? 1'b0 : (pend_q | load);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_cmp_ch #(
      .W   (W),
      .INV (INV_MASK[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .apply_i (apply),
      .run_i   (run),
      .blank_i (blank),
      .duty_i  (duty[i*W +: W]),
      .cnt_i   (cnt_q),
      .pwm_o   (pwm[i])
    );
  end

  assign period_tick = tick_q;
  assign upd_pending = pend_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: period-position reference model checked every cycle,
// plus directed per-period high/tick counts against hand-computed values.
module tb_pwm_multi_ch;
  logic        clk = 1'b0;
  logic        rst, en, load;
  logic        cfg_mode;
  logic [7:0]  cfg_p;
  logic [7:0]  cfg_d [4];
  logic [31:0] duty;
  logic [3:0]  pwm, pwm_inv;
  logic        tick, tick_inv, pend, pend_inv;

  int vectors = 0;
  int miscompares = 0;
  int hi [4];
  int ticks;
  bit pend_seen, last_tick;

  always #5 clk = ~clk;

  assign duty = {cfg_d[3], cfg_d[2], cfg_d[1], cfg_d[0]};

  pwm_multi_ch #(.CH(4), .W(8), .INV_MASK(4'b0000)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(cfg_mode), .period(cfg_p),
    .duty(duty), .pwm(pwm), .period_tick(tick), .upd_pending(pend));

  pwm_multi_ch #(.CH(4), .W(8), .INV_MASK(4'b0101)) dut_inv (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(cfg_mode), .period(cfg_p),
    .duty(duty), .pwm(pwm_inv), .period_tick(tick_inv), .upd_pending(pend_inv));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current period, not counter/direction.
  typedef struct packed {
    logic        center;
    logic [7:0]  p;
    logic [31:0] d;
  } cfg_t;

  cfg_t       m_act, m_sh, m_in;
  int         m_pos;
  bit         m_run;
  logic [3:0] exp_pwm;
  logic       exp_tick, exp_pend;

  always @(posedge clk) begin
    m_in = '{center: cfg_mode, p: cfg_p, d: duty};
    if (!rst) begin
      m_act = '0; m_sh = '0; m_pos = 0; m_run = 1'b0;
      exp_pwm = 4'b0; exp_tick = 1'b0; exp_pend = 1'b0;
    end else if (!en) begin
      m_run = 1'b0; m_pos = 0; exp_pwm = 4'b0; exp_tick = 1'b0;
      if (load) begin m_sh = m_in; exp_pend = 1'b1; end
    end else if (!m_run) begin
      if (load) m_sh = m_in;
      m_act = m_sh; exp_pend = 1'b0; m_run = 1'b1; m_pos = 0;
      exp_pwm = 4'b0; exp_tick = 1'b0;
    end else begin
      int  p, c;
      bit  last, dead;
      p    = int'(m_act.p);
      dead = m_act.center && (p == 0);
      if (!m_act.center) begin
        c = m_pos; last = (m_pos == p);
      end else begin
        c = (m_pos < p) ? m_pos : 2 * p - 1 - m_pos;
        last = !dead && (m_pos == 2 * p - 1);
      end
      for (int ch = 0; ch < 4; ch++)
        exp_pwm[ch] = !dead && (c < int'(m_act.d[ch*8 +: 8]));
      exp_tick = last;
      if (last) begin
        if (load) m_sh = m_in;
        m_act = m_sh; exp_pend = 1'b0; m_pos = 0;
      end else begin
        if (load) begin m_sh = m_in; exp_pend = 1'b1; end
        if (!dead) m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    chk("pwm", 32'(pwm), 32'(exp_pwm));
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("pend", 32'(pend), 32'(exp_pend));
    chk("pwm_inv", 32'(pwm_inv), 32'(exp_pwm ^ 4'b0101));
    chk("tick_inv", 32'(tick_inv), 32'(exp_tick));
    chk("pend_inv", 32'(pend_inv), 32'(exp_pend));
  end

  task automatic set_cfg(input logic m, input logic [7:0] p,
                         input logic [7:0] d0, d1, d2, d3);
    cfg_mode = m; cfg_p = p;
    cfg_d[0] = d0; cfg_d[1] = d1; cfg_d[2] = d2; cfg_d[3] = d3;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 100);
    chk("wait_tick", 32'(tick), 32'd1);
  endtask

  // Samples n output cycles; optionally strobes load on iteration ld_at.
  task automatic run_count(input int n, input int ld_at);
    for (int ch = 0; ch < 4; ch++) hi[ch] = 0;
    ticks = 0; pend_seen = 1'b0; last_tick = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load = (i == ld_at);
      for (int ch = 0; ch < 4; ch++) hi[ch] = hi[ch] + int'(pwm[ch]);
      ticks     = ticks + int'(tick);
      pend_seen = pend_seen | pend;
      last_tick = tick;
    end
  endtask

  task automatic chk_hi(input string name, input int h0, h1, h2, h3);
    chk({name, "_hi0"}, 32'(hi[0]), 32'(h0));
    chk({name, "_hi1"}, 32'(hi[1]), 32'(h1));
    chk({name, "_hi2"}, 32'(hi[2]), 32'(h2));
    chk({name, "_hi3"}, 32'(hi[3]), 32'(h3));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0;
    set_cfg(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm), 32'h0);
    chk("rst_pwm_inv", 32'(pwm_inv), 32'h5);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    rst = 1'b1;

    // Edge, P=9, D={0,3,10,255}
    set_cfg(1'b0, 8'd9, 8'd0, 8'd3, 8'd10, 8'd255);
    pulse_load();
    chk("t1_pend", 32'(pend), 32'd1);
    en = 1'b1;
    wait_tick();
    run_count(10, -1);
    chk_hi("t1", 0, 3, 10, 10);
    chk("t1_ticks", 32'(ticks), 32'd1);
    chk("t1_last_tick", 32'(last_tick), 32'd1);

    // Center, P=8, D=3
    set_cfg(1'b1, 8'd8, 8'd3, 8'd3, 8'd3, 8'd3);
    pulse_load();
    wait_tick();
    run_count(16, -1);
    chk_hi("t2", 6, 6, 6, 6);
    chk("t2_ticks", 32'(ticks), 32'd1);
    chk("t2_last_tick", 32'(last_tick), 32'd1);

    // Mid-period load D=7 over D=2
    set_cfg(1'b0, 8'd9, 8'd2, 8'd2, 8'd2, 8'd2);
    pulse_load();
    wait_tick();
    set_cfg(1'b0, 8'd9, 8'd7, 8'd7, 8'd7, 8'd7);
    run_count(10, 3);
    chk_hi("t3a", 2, 2, 2, 2);
    chk("t3_pend_seen", 32'(pend_seen), 32'd1);
    run_count(10, -1);
    chk_hi("t3b", 7, 7, 7, 7);

    // Load on the terminal cycle goes straight to active
    set_cfg(1'b0, 8'd5, 8'd1, 8'd2, 8'd5, 8'd6);
    run_count(10, 8);
    chk("t4_pend_seen", 32'(pend_seen), 32'd0);
    chk("t4_last_tick", 32'(last_tick), 32'd1);
    run_count(6, -1);
    chk_hi("t4", 1, 2, 5, 6);
    chk("t4_ticks", 32'(ticks), 32'd1);
    chk("t4_last_tick2", 32'(last_tick), 32'd1);

    // en=0 idles outputs, then reset mid-period
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t5_pwm_inv", 32'(pwm_inv), 32'h5);
    chk("t5_tick_inv", 32'(tick_inv), 32'h0);
    chk("t5_pwm", 32'(pwm), 32'h0);
    set_cfg(1'b0, 8'd9, 8'd4, 8'd4, 8'd4, 8'd4);
    pulse_load();
    chk("t5_pend", 32'(pend_inv), 32'd1);
    en = 1'b1;
    wait_tick();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5r_pwm_inv", 32'(pwm_inv), 32'h5);
    chk("t5r_tick_inv", 32'(tick_inv), 32'h0);
    chk("t5r_pend", 32'(pend_inv), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Edge P=0 D=1, then center P=0
    set_cfg(1'b0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1);
    pulse_load();
    wait_tick();
    run_count(5, -1);
    chk_hi("t6a", 5, 5, 5, 5);
    chk("t6a_ticks", 32'(ticks), 32'd5);
    set_cfg(1'b1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1);
    pulse_load();
    run_count(10, -1);
    chk_hi("t6b", 0, 0, 0, 0);
    chk("t6b_ticks", 32'(ticks), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
